selftrigger_config_sequencer: RTL



---
 rtl/selftrigger_config_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/selftrigger_config_sequencer.sv
// Per-channel self-trigger reconfiguration sequencer. It disables a channel, flushes it,
// loads the new threshold and selector, re-enables it, and masks its trigger while the filters settle.
module selftrigger_config_sequencer #(
   parameter int          NUM_CH               = 8,
   parameter int          FLUSH_CYCLES         = 16,
   parameter int          SETTLE_CYCLES        = 1024,
   parameter logic [41:0] DEFAULT_THRESHOLD_XC = 42'd0,
   parameter logic [1:0]  DEFAULT_SELECTOR     = 2'b00
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   run_i,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [7:0]             cfg_ch_i,
   input  logic [41:0]            cfg_threshold_xc_i,
   input  logic [1:0]             cfg_selector_i,
   output logic                   cfg_done_o,
   output logic                   cfg_err_o,
   output logic                   busy_o,
   output logic [NUM_CH-1:0]      ch_enable_o,
   output logic [42*NUM_CH-1:0]   ch_threshold_xc_o,
   output logic [2*NUM_CH-1:0]    ch_output_selector_o,
   input  logic [NUM_CH-1:0]      trig_in_i,
   output logic [NUM_CH-1:0]      trig_out_o
);

   localparam int MAX_CYC = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [8:0]       NUM_CH_LIM  = 9'(NUM_CH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_DISABLE = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_SETTLE  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_GSETTLE = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [41:0]      req_thr_q, req_thr_d;
   logic [1:0]       req_sel_q, req_sel_d;
   logic             gpend_q, gpend_d;
   logic             err_q, err_d;
   logic             run_q;

   logic accept, ch_bad, cnt_zero, run_rise;
   logic hold_set, load_stb, settle_ch_clr, settle_all_set, settle_all_clr;

   assign run_rise    = run_i & ~run_q;
   assign cfg_ready_o = (state_q == S_IDLE) & ~gpend_q;
   assign accept      = cfg_valid_i & cfg_ready_o;
   assign ch_bad      = ({1'b0, cfg_ch_i} >= NUM_CH_LIM);
   assign cnt_zero    = (cnt_q == '0);
   assign cfg_done_o  = (state_q == S_DONE);
   assign cfg_err_o   = err_q;
   assign busy_o      = (state_q != S_IDLE);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ch_d           = ch_q;
      req_thr_d      = req_thr_q;
      req_sel_d      = req_sel_q;
      err_d          = 1'b0;
      gpend_d        = gpend_q | run_rise;
      hold_set       = 1'b0;
      load_stb       = 1'b0;
      settle_ch_clr  = 1'b0;
      settle_all_set = 1'b0;
      settle_all_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A pending global settle wins; cfg_ready is already low while it waits.
            if (gpend_q) begin
               state_d        = S_GSETTLE;
               cnt_d          = SETTLE_LOAD;
               settle_all_set = 1'b1;
               gpend_d        = run_rise;
            end else if (accept) begin
               if (ch_bad) begin
                  err_d = 1'b1;
               end else begin
                  ch_d      = cfg_ch_i[CH_W-1:0];
                  req_thr_d = cfg_threshold_xc_i;
                  req_sel_d = cfg_selector_i;
                  hold_set  = 1'b1;
                  cnt_d     = FLUSH_LOAD;
                  state_d   = S_DISABLE;
               end
            end
         end
         S_DISABLE: begin
            if (cnt_zero) state_d = S_LOAD;
            else          cnt_d   = cnt_q - CNT_W'(1);
         end
         S_LOAD: begin
            load_stb = 1'b1;
            cnt_d    = SETTLE_LOAD;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_zero) begin
               settle_ch_clr = 1'b1;
               state_d       = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_GSETTLE: begin
            if (cnt_zero) begin
               settle_all_clr = 1'b1;
               state_d        = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // run_q resets high so a run level already present at reset release is not
   // seen as a new rising edge; the reset GSETTLE already covers that case.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_GSETTLE;
         cnt_q     <= SETTLE_LOAD;
         ch_q      <= '0;
         req_thr_q <= DEFAULT_THRESHOLD_XC;
         req_sel_q <= DEFAULT_SELECTOR;
         gpend_q   <= 1'b0;
         err_q     <= 1'b0;
         run_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ch_q      <= ch_d;
         req_thr_q <= req_thr_d;
         req_sel_q <= req_sel_d;
         gpend_q   <= gpend_d;
         err_q     <= err_d;
         run_q     <= run_i;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic        hit_acc, hit_cur;
         logic        hold_q, settle_q, trig_q;
         logic [41:0] thr_q;
         logic [1:0]  sel_q;

         assign hit_acc = (cfg_ch_i[CH_W-1:0] == CH_W'(gi));
         assign hit_cur = (ch_q == CH_W'(gi));

         assign ch_enable_o[gi]                  = run_i & ~hold_q;
         assign trig_out_o[gi]                   = trig_q;
         assign ch_threshold_xc_o[42*gi +: 42]   = thr_q;
         assign ch_output_selector_o[2*gi +: 2]  = sel_q;

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               hold_q   <= 1'b0;
               settle_q <= 1'b1;
               trig_q   <= 1'b0;
               thr_q    <= DEFAULT_THRESHOLD_XC;
               sel_q    <= DEFAULT_SELECTOR;
            end else begin
               if (hold_set && hit_acc)
                  hold_q <= 1'b1;
               else if (load_stb && hit_cur)
                  hold_q <= 1'b0;

               if (settle_all_set)
                  settle_q <= 1'b1;
               else if (settle_all_clr)
                  settle_q <= 1'b0;
               else if (load_stb && hit_cur)
                  settle_q <= 1'b1;
               else if (settle_ch_clr && hit_cur)
                  settle_q <= 1'b0;

               // Values only move on the LOAD edge, while this channel is still held off.
               if (load_stb && hit_cur) begin
                  thr_q <= req_thr_q;
                  sel_q <= req_sel_q;
               end

               trig_q <= trig_in_i[gi] & run_i & ~hold_q & ~settle_q;
            end
         end
      end
   endgenerate

endmodule
